// File: rtl/aes_inv_key_schedule.sv
// rtl/aes_inv_key_schedule.sv - AES-128 inverse key schedule, round 10 down to round 0
// Optional `AES_INV_KS_PRECOMPUTE_EN: key_in is the cipher key, expanded forward first.
module aes_inv_key_schedule (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic         key_ready,
  output logic [127:0] round_key,
  output logic [3:0]   round_num,
  output logic         key_valid,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
`ifdef AES_INV_KS_PRECOMPUTE_EN
    FWD  = 2'd3,
`endif
    FIN  = 2'd2
  } state_t;

  state_t       state, state_n;
  logic [127:0] key_n;
  logic [3:0]   num_n;
  logic         valid_n, busy_n, done_n;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box as GF(2^8) inverse (x^254) followed by the affine transform
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = b;
    inv = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_rot(input logic [31:0] w);
    return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] inv_step(input logic [127:0] k, input logic [3:0] r);
    logic [31:0] p0, p1, p2, p3;
    p3 = k[31:0]   ^ k[63:32];
    p2 = k[63:32]  ^ k[95:64];
    p1 = k[95:64]  ^ k[127:96];
    p0 = k[127:96] ^ sub_rot(p3) ^ {rcon(r), 24'h0};
    return {p0, p1, p2, p3};
  endfunction

`ifdef AES_INV_KS_PRECOMPUTE_EN
  function automatic logic [127:0] fwd_step(input logic [127:0] k, input logic [3:0] r);
    logic [31:0] n0, n1, n2, n3;
    n0 = k[127:96] ^ sub_rot(k[31:0]) ^ {rcon(r), 24'h0};
    n1 = k[95:64]  ^ n0;
    n2 = k[63:32]  ^ n1;
    n3 = k[31:0]   ^ n2;
    return {n0, n1, n2, n3};
  endfunction
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      round_key <= '0;
      round_num <= '0;
      key_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      round_key <= key_n;
      round_num <= num_n;
      key_valid <= valid_n;
      busy      <= busy_n;
      done      <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    key_n   = round_key;
    num_n   = round_num;
    valid_n = key_valid;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          key_n = key_in;
`ifdef AES_INV_KS_PRECOMPUTE_EN
          // round_num doubles as the forward Rcon index while key_valid is low
          state_n = FWD;
          num_n   = 4'd1;
          valid_n = 1'b0;
`else
          state_n = EMIT;
          num_n   = 4'd10;
          valid_n = 1'b1;
`endif
        end
      end
`ifdef AES_INV_KS_PRECOMPUTE_EN
      FWD: begin
        key_n = fwd_step(round_key, round_num);
        if (round_num == 4'd10) begin
          state_n = EMIT;
          valid_n = 1'b1;
        end else begin
          num_n = 4'(round_num + 4'd1);
        end
      end
`endif
      EMIT: begin
        if (key_ready) begin
          if (round_num == 4'd0) begin
            state_n = FIN;
            valid_n = 1'b0;
            done_n  = 1'b1;
          end else begin
            key_n = inv_step(round_key, round_num);
            num_n = 4'(round_num - 4'd1);
          end
        end
      end
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_aes_inv_key_schedule.sv
// tb/tb_aes_inv_key_schedule.sv - self-checking bench for aes_inv_key_schedule
// Follows the DUT build: define AES_INV_KS_PRECOMPUTE_EN for both to test the forward mode.
module tb_aes_inv_key_schedule;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         key_ready = 1'b0;
  logic [127:0] key_in = '0;
  logic [127:0] round_key;
  logic [3:0]   round_num;
  logic         key_valid, busy, done;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  aes_inv_key_schedule dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key_in(key_in), .key_ready(key_ready),
    .round_key(round_key), .round_num(round_num), .key_valid(key_valid),
    .busy(busy), .done(done)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: S-box table, and all 44 schedule words as a plain array
  logic [7:0]   sbox_t [256];
  logic [127:0] keys [11];

  function automatic void build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox_t[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_t[0] = 8'h63;
  endfunction

  function automatic logic [31:0] sub_rot(input logic [31:0] w);
    return {sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]], sbox_t[w[31:24]]};
  endfunction

  function automatic void model_keys(input logic [127:0] k, input bit from_cipher);
    logic [31:0] w [44];
    logic [7:0]  rc [11];
    rc[0] = 8'h00;
    rc[1] = 8'h01;
    for (int i = 2; i <= 10; i++) rc[i] = {rc[i-1][6:0], 1'b0} ^ (rc[i-1][7] ? 8'h1b : 8'h00);
    if (from_cipher) begin
      for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
      for (int i = 4; i < 44; i++)
        w[i] = w[i-4] ^ ((i % 4 == 0) ? (sub_rot(w[i-1]) ^ {rc[i/4], 24'h0}) : w[i-1]);
    end else begin
      for (int i = 0; i < 4; i++) w[40+i] = k[127-32*i -: 32];
      for (int i = 43; i >= 4; i--)
        w[i-4] = w[i] ^ ((i % 4 == 0) ? (sub_rot(w[i-1]) ^ {rc[i/4], 24'h0}) : w[i-1]);
    end
    for (int r = 0; r <= 10; r++) keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  task automatic load_model(input logic [127:0] k);
`ifdef AES_INV_KS_PRECOMPUTE_EN
    model_keys(k, 1'b1);
`else
    model_keys(k, 1'b0);
`endif
  endtask

  // Cycle-level protocol model, compared on every falling edge
  bit m_busy = 0, m_valid = 0, m_done = 0;
  int m_rn = 0, m_fwd = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst round_key", round_key, 128'h0);
      check("rst round_num", 128'(round_num), 128'h0);
      check("rst key_valid", 128'(key_valid), 128'h0);
      check("rst busy", 128'(busy), 128'h0);
      check("rst done", 128'(done), 128'h0);
      m_busy <= 0; m_valid <= 0; m_done <= 0; m_rn <= 0; m_fwd <= 0;
    end else begin
      check("key_valid", 128'(key_valid), 128'(m_valid));
      check("busy", 128'(busy), 128'(m_busy));
      check("done", 128'(done), 128'(m_done));
      if (m_valid) begin
        check("round_num", 128'(round_num), 128'(m_rn));
        check("round_key", round_key, keys[m_rn]);
      end
      if (m_done) begin
        m_done <= 0;
        m_busy <= 0;
      end else if (!m_busy) begin
        if (start) begin
          m_busy <= 1;
`ifdef AES_INV_KS_PRECOMPUTE_EN
          m_fwd <= 10;
`else
          m_valid <= 1;
          m_rn <= 10;
`endif
        end
      end else if (m_fwd > 0) begin
        m_fwd <= m_fwd - 1;
        if (m_fwd == 1) begin
          m_valid <= 1;
          m_rn <= 10;
        end
      end else if (m_valid && key_ready) begin
        if (m_rn == 0) begin
          m_valid <= 0;
          m_done <= 1;
        end else begin
          m_rn <= m_rn - 1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rn(input int r);
    int n = 0;
    while (!(key_valid && round_num == 4'(r)) && n < 40) begin
      tick();
      n++;
    end
    check("wait for round", 128'(key_valid && round_num == 4'(r)), 128'h1);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 40) begin
      tick();
      n++;
    end
    check("wait for done", 128'(done), 128'h1);
  endtask

  task automatic kick();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int cyc;
    int done_cyc;
    build_sbox();
    check("sbox 00", 128'(sbox_t[8'h00]), 128'h63);
    check("sbox 01", 128'(sbox_t[8'h01]), 128'h7c);
    check("sbox 53", 128'(sbox_t[8'h53]), 128'hed);
    check("sbox ff", 128'(sbox_t[8'hff]), 128'h16);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Known FIPS-197 schedule, uninterrupted
`ifdef AES_INV_KS_PRECOMPUTE_EN
    key_in = 128'h2b7e151628aed2a6abf7158809cf4f3c;
`else
    key_in = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
`endif
    load_model(key_in);
    check("model k10", keys[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    check("model k9", keys[9], 128'hac7766f319fadc2128d12941575c006e);
    check("model k0", keys[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);
    key_ready = 1'b1;
    kick();
`ifdef AES_INV_KS_PRECOMPUTE_EN
    for (int i = 0; i < 10; i++) begin
      check("fwd key_valid low", 128'(key_valid), 128'h0);
      tick();
    end
`endif
    check("first key_valid", 128'(key_valid), 128'h1);
    check("first round_num", 128'(round_num), 128'd10);
    check("first round_key", round_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    tick();
    check("second round_num", 128'(round_num), 128'd9);
    check("second round_key", round_key, 128'hac7766f319fadc2128d12941575c006e);
    cyc = 2;
    done_cyc = 0;
    while (!done && cyc < 30) begin
      if (key_valid && round_num == 4'd0)
        check("final round_key", round_key, 128'h2b7e151628aed2a6abf7158809cf4f3c);
      tick();
      cyc++;
    end
    if (done) done_cyc = cyc;
    check("done cycle", 128'(done_cyc), 128'd12);
    tick();
    check("idle after fin", 128'(busy), 128'h0);

    // Back-pressure hold at round 7
    key_in = 128'h000102030405060708090a0b0c0d0e0f;
    load_model(key_in);
    kick();
    wait_rn(7);
    key_ready = 1'b0;
    repeat (5) begin
      tick();
      check("hold round_num", 128'(round_num), 128'd7);
      check("hold round_key", round_key, keys[7]);
    end
    key_ready = 1'b1;
    tick();
    check("resume round_num", 128'(round_num), 128'd6);
    check("resume round_key", round_key, keys[6]);
    wait_done();
    tick();

    // start while busy and during FIN is ignored; restart after one idle cycle
    key_in = 128'h3c4fcf098815f7aba6d2ae2816157e2b;
    load_model(key_in);
    kick();
    wait_rn(4);
    kick();
    wait_done();
    kick();
    check("fin start ignored busy", 128'(busy), 128'h0);
    check("fin start ignored valid", 128'(key_valid), 128'h0);
    kick();
    check("restart busy", 128'(busy), 128'h1);
    wait_done();
    tick();

    // Asynchronous reset mid-sequence
    key_in = 128'hffeeddccbbaa99887766554433221100;
    load_model(key_in);
    kick();
    wait_rn(5);
    #2;
    rst_n = 1'b0;
    #1;
    check("async round_key", round_key, 128'h0);
    check("async round_num", 128'(round_num), 128'h0);
    check("async key_valid", 128'(key_valid), 128'h0);
    check("async busy", 128'(busy), 128'h0);
    check("async done", 128'(done), 128'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    kick();
    check("post-reset start busy", 128'(busy), 128'h1);
    wait_done();
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
